line_render_scheduler: RTL and testbench
========================================

Name: line_render_scheduler

Overview:
- Sequences per-scanline rendering for the three line-buffer producers: layer0, layer1 and sprite renderers.
- Triggered by the compositor's line_render_start/line_idx. Starts each enabled renderer, tracks completion and flips the double-buffered line-buffer bank.
- Arbitrates the single shared VRAM read port among the three renderers.
- Sits between the compositor and the renderers/VRAM controller.

Parameters:
- VRAM_AW, 17, VRAM word-address width.
- VRAM_DW, 32, VRAM read-data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- line_render_start  in  1  one-cycle pulse: render line line_idx
- line_idx  in  9  scaled source line index
- layer0_enabled, layer1_enabled, sprites_enabled  in  1 each  renderer enables
- rnd_start  out  3  one-hot-per-renderer start pulses; bit0=layer0, bit1=layer1, bit2=sprites
- rnd_line_idx  out  9  latched line index for renderers
- rnd_done  in  3  per-renderer done pulses
- rnd_vram_req  in  3  VRAM read requests
- rnd_vram_addr  in  3*VRAM_AW  request addresses; renderer i at bits [i*VRAM_AW +: VRAM_AW]
- rnd_vram_gnt  out  3  one-hot grant, combinational in the request cycle
- rnd_vram_rdvalid  out  3  one-hot data-valid, one cycle after grant
- vram_rd_en  out  1  shared VRAM read strobe
- vram_addr  out  VRAM_AW  muxed address
- vram_rddata  in  VRAM_DW  VRAM data, valid one cycle after vram_rd_en; renderers sample it directly
- lb_render_bank  out  1  line-buffer bank being written; display reads ~lb_render_bank
- line_done  out  1  one-cycle pulse when all enabled renderers finish
- overrun  out  1  sticky overrun flag
- overrun_clr  in  1  clears overrun and overrun_count
- overrun_count  out  8  saturating overrun counter

Behaviour:
Reset:
- rst is synchronous, active-high; clock is clk.
- Reset values: all outputs 0, FSM=IDLE, pending mask=0, arbiter pointer=0 (layer0), rdvalid pipeline cleared.

FSM states: IDLE, START, RENDER.
- IDLE, line_render_start=1 → START:
  - Latch line_idx into rnd_line_idx.
  - Latch enables into pending[2:0].
- START (one cycle):
  - rnd_start = pending.
  - If pending==0 → DONE path; otherwise → RENDER.
- RENDER:
  - rnd_done[i] clears pending[i].
  - rnd_done on a bit not pending is ignored.
  - When pending becomes 0 → DONE path.
- DONE path: next cycle line_done=1, lb_render_bank toggles, FSM → IDLE.
- Latency: line_render_start to rnd_start = 1 cycle. A line with all renderers disabled gives line_done 2 cycles after line_render_start and still toggles the bank.

Overrun (line_render_start while in START or RENDER):
- Set overrun; increment overrun_count, saturating at 255.
- Do not toggle the bank and do not pulse line_done.
- Relatch line_idx and enables, then go to START (renderers restart on the new line).
- overrun_clr has priority over a same-cycle increment.

rnd_done and line_render_start in the same cycle in RENDER: the overrun rule wins.

Arbiter:
- Eligible request: rnd_vram_req[i] && pending[i] && state==RENDER.
- Round-robin from the pointer; at most one grant per cycle.
- After grant i, pointer = (i+1) mod 3.
- vram_rd_en = |gnt; vram_addr = address of granted renderer, 0 when idle.
- rnd_vram_rdvalid = gnt delayed by 1 cycle.
- A requester holds req and addr until granted; back-to-back grants to the same requester are allowed only when no other eligible request exists.
- A grant and a done from the same renderer in one cycle: the grant is issued, and its rdvalid still fires.

Optional Feature:
- Macro: LRS_SPRITE_PRIORITY_EN.
- Defined: sprites (bit2) get fixed highest priority; layer0/layer1 round-robin between themselves; the pointer does not advance on sprite grants.
- Undefined: pure 3-way round-robin as above.

Test Plan:
- All enabled, line_render_start with line_idx=37: rnd_start=3'b111 one cycle later and rnd_line_idx=37; after dones at cycles +5/+9/+12, line_done fires once, 1 cycle after the last done, and lb_render_bank goes 0→1.
- Only layer1 enabled: rnd_start=3'b010; the layer0 done pulse is ignored; line_done follows layer1 done.
- All disabled: line_done 2 cycles after start, bank toggles, no rnd_start bits set.
- All three requesting continuously: grants rotate 001,010,100,001…; vram_addr matches; each rdvalid lags its grant by 1 cycle. With LRS_SPRITE_PRIORITY_EN: 100 every cycle.
- Second line_render_start while sprites still pending: overrun=1, overrun_count=1, no bank toggle, rnd_start re-pulsed with new line_idx; overrun_clr → both 0. 256 overruns → count saturates at 255.
- rst asserted mid-RENDER with a grant active: next cycle all outputs 0, IDLE, no rdvalid for the aborted grant.

Source files
------------

// File: rtl/line_render_scheduler.sv
// Per-scanline render sequencer and round-robin VRAM read arbiter for three renderers.
// Define LRS_SPRITE_PRIORITY_EN to give sprites fixed top VRAM priority.
module line_render_scheduler #(
  parameter int VRAM_AW = 17,
  parameter int VRAM_DW = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   line_render_start,
  input  logic [8:0]             line_idx,
  input  logic                   layer0_enabled,
  input  logic                   layer1_enabled,
  input  logic                   sprites_enabled,
  output logic [2:0]             rnd_start,
  output logic [8:0]             rnd_line_idx,
  input  logic [2:0]             rnd_done,
  input  logic [2:0]             rnd_vram_req,
  input  logic [3*VRAM_AW-1:0]   rnd_vram_addr,
  output logic [2:0]             rnd_vram_gnt,
  output logic [2:0]             rnd_vram_rdvalid,
  output logic                   vram_rd_en,
  output logic [VRAM_AW-1:0]     vram_addr,
  input  logic [VRAM_DW-1:0]     vram_rddata,
  output logic                   lb_render_bank,
  output logic                   line_done,
  output logic                   overrun,
  input  logic                   overrun_clr,
  output logic [7:0]             overrun_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    RENDER = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] pending_q, pending_d;
  logic [8:0] idx_d;
  logic       done_d;
  logic       bank_d;
  logic       fin;
  logic       busy;
  logic       ovr_hit;
  logic [2:0] enables;
  logic [2:0] elig;
  logic [1:0] ptr, ptr_d;
  logic       unused_rddata;

  // Renderers take VRAM data straight from the controller.
  assign unused_rddata = ^vram_rddata;

  assign enables = {sprites_enabled, layer1_enabled, layer0_enabled};
  assign busy    = (state_q != IDLE);
  assign ovr_hit = line_render_start && busy;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    idx_d     = rnd_line_idx;
    done_d    = 1'b0;
    bank_d    = lb_render_bank;
    rnd_start = 3'b000;
    fin       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (line_render_start) begin
          state_d   = START;
          pending_d = enables;
          idx_d     = line_idx;
        end
      end
      START: begin
        rnd_start = pending_q;
        if (pending_q == 3'b000) fin = 1'b1;
        else state_d = RENDER;
      end
      RENDER: begin
        pending_d = pending_q & ~rnd_done;
        if (pending_d == 3'b000) fin = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (fin) begin
      state_d = IDLE;
      done_d  = 1'b1;
      bank_d  = ~lb_render_bank;
    end
    // A new line while busy abandons the current one and restarts.
    if (ovr_hit) begin
      state_d   = START;
      pending_d = enables;
      idx_d     = line_idx;
      done_d    = 1'b0;
      bank_d    = lb_render_bank;
    end
  end

  assign elig = rnd_vram_req & pending_q & {3{state_q == RENDER}};

`ifdef LRS_SPRITE_PRIORITY_EN
  always_comb begin
    rnd_vram_gnt = 3'b000;
    if (elig[2]) rnd_vram_gnt = 3'b100;
    else if (ptr == 2'd1) begin
      if (elig[1]) rnd_vram_gnt = 3'b010;
      else if (elig[0]) rnd_vram_gnt = 3'b001;
    end else begin
      if (elig[0]) rnd_vram_gnt = 3'b001;
      else if (elig[1]) rnd_vram_gnt = 3'b010;
    end
  end

  always_comb begin
    ptr_d = ptr;
    unique case (1'b1)
      rnd_vram_gnt[0]: ptr_d = 2'd1;
      rnd_vram_gnt[1]: ptr_d = 2'd0;
      default:         ptr_d = ptr;
    endcase
  end
`else
  always_comb begin
    rnd_vram_gnt = 3'b000;
    case (ptr)
      2'd0: begin
        if (elig[0]) rnd_vram_gnt = 3'b001;
        else if (elig[1]) rnd_vram_gnt = 3'b010;
        else if (elig[2]) rnd_vram_gnt = 3'b100;
      end
      2'd1: begin
        if (elig[1]) rnd_vram_gnt = 3'b010;
        else if (elig[2]) rnd_vram_gnt = 3'b100;
        else if (elig[0]) rnd_vram_gnt = 3'b001;
      end
      2'd2: begin
        if (elig[2]) rnd_vram_gnt = 3'b100;
        else if (elig[0]) rnd_vram_gnt = 3'b001;
        else if (elig[1]) rnd_vram_gnt = 3'b010;
      end
      default: rnd_vram_gnt = 3'b000;
    endcase
  end

  always_comb begin
    ptr_d = ptr;
    unique case (1'b1)
      rnd_vram_gnt[0]: ptr_d = 2'd1;
      rnd_vram_gnt[1]: ptr_d = 2'd2;
      rnd_vram_gnt[2]: ptr_d = 2'd0;
      default:         ptr_d = ptr;
    endcase
  end
`endif

  assign vram_rd_en = |rnd_vram_gnt;

  always_comb begin
    vram_addr = '0;
    unique case (1'b1)
      rnd_vram_gnt[0]: vram_addr = rnd_vram_addr[0*VRAM_AW +: VRAM_AW];
      rnd_vram_gnt[1]: vram_addr = rnd_vram_addr[1*VRAM_AW +: VRAM_AW];
      rnd_vram_gnt[2]: vram_addr = rnd_vram_addr[2*VRAM_AW +: VRAM_AW];
      default:         vram_addr = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      pending_q        <= 3'b000;
      rnd_line_idx     <= '0;
      line_done        <= 1'b0;
      lb_render_bank   <= 1'b0;
      ptr              <= 2'd0;
      rnd_vram_rdvalid <= 3'b000;
      overrun          <= 1'b0;
      overrun_count    <= 8'd0;
    end else begin
      state_q          <= state_d;
      pending_q        <= pending_d;
      rnd_line_idx     <= idx_d;
      line_done        <= done_d;
      lb_render_bank   <= bank_d;
      ptr              <= ptr_d;
      rnd_vram_rdvalid <= rnd_vram_gnt;
      if (overrun_clr) begin
        overrun       <= 1'b0;
        overrun_count <= 8'd0;
      end else if (ovr_hit) begin
        overrun <= 1'b1;
        if (overrun_count != 8'hFF) overrun_count <= overrun_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_line_render_scheduler.sv
// Directed bench for line_render_scheduler with a per-cycle reference model.
`timescale 1ns/1ps
module tb_line_render_scheduler;
  localparam int AW = 17;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            lrs = 1'b0;
  logic [8:0]      line_idx = '0;
  logic            en0 = 1'b0, en1 = 1'b0, en2 = 1'b0;
  logic [2:0]      rnd_start;
  logic [8:0]      rnd_line_idx;
  logic [2:0]      rnd_done = '0;
  logic [2:0]      rnd_vram_req = '0;
  logic [3*AW-1:0] rnd_vram_addr = {17'h1_3333, 17'h0_2222, 17'h0_0111};
  logic [2:0]      rnd_vram_gnt;
  logic [2:0]      rnd_vram_rdvalid;
  logic            vram_rd_en;
  logic [AW-1:0]   vram_addr;
  logic [DW-1:0]   vram_rddata = 32'hDEAD_BEEF;
  logic            lb_render_bank;
  logic            line_done;
  logic            overrun;
  logic            overrun_clr = 1'b0;
  logic [7:0]      overrun_count;

  line_render_scheduler #(.VRAM_AW(AW), .VRAM_DW(DW)) dut (
    .clk(clk), .rst(rst),
    .line_render_start(lrs), .line_idx(line_idx),
    .layer0_enabled(en0), .layer1_enabled(en1), .sprites_enabled(en2),
    .rnd_start(rnd_start), .rnd_line_idx(rnd_line_idx),
    .rnd_done(rnd_done), .rnd_vram_req(rnd_vram_req),
    .rnd_vram_addr(rnd_vram_addr), .rnd_vram_gnt(rnd_vram_gnt),
    .rnd_vram_rdvalid(rnd_vram_rdvalid), .vram_rd_en(vram_rd_en),
    .vram_addr(vram_addr), .vram_rddata(vram_rddata),
    .lb_render_bank(lb_render_bank), .line_done(line_done),
    .overrun(overrun), .overrun_clr(overrun_clr),
    .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0=idle, 1=start pulse, 2=rendering.
  int         m_phase = 0;
  logic [2:0] m_pend = '0;
  logic [8:0] m_idx = '0;
  logic       m_done = 1'b0;
  logic       m_bank = 1'b0;
  logic       m_ovr = 1'b0;
  int         m_cnt = 0;
  int         m_ptr = 0;
  logic [2:0] m_rdv = '0;
  bit         armed = 1'b0;

  function automatic logic [2:0] pick(input logic [2:0] el, input int ptr);
    pick = 3'b000;
`ifdef LRS_SPRITE_PRIORITY_EN
    if (el[2]) return 3'b100;
    for (int k = 0; k < 2; k++) begin
      int i;
      i = (ptr + k) % 2;
      if (el[i]) return 3'(1 << i);
    end
`else
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (ptr + k) % 3;
      if (el[i]) return 3'(1 << i);
    end
`endif
  endfunction

  function automatic int gidx(input logic [2:0] g);
    gidx = -1;
    for (int i = 0; i < 3; i++) if (g[i]) gidx = i;
  endfunction

  function automatic logic [2:0] m_elig();
    return (m_phase == 2) ? (rnd_vram_req & m_pend) : 3'b000;
  endfunction

  always @(posedge clk) begin : model
    logic [2:0] g;
    int gi;
    g = pick(m_elig(), m_ptr);
    gi = gidx(g);
    if (rst) begin
      m_phase = 0; m_pend = '0; m_idx = '0; m_done = 0; m_bank = 0;
      m_ovr = 0; m_cnt = 0; m_ptr = 0; m_rdv = '0; armed = 1'b1;
    end else begin
      m_rdv = g;
`ifdef LRS_SPRITE_PRIORITY_EN
      if (gi >= 0 && gi != 2) m_ptr = (gi + 1) % 2;
`else
      if (gi >= 0) m_ptr = (gi + 1) % 3;
`endif
      m_done = 1'b0;
      if (overrun_clr) begin
        m_ovr = 0; m_cnt = 0;
      end else if (lrs && m_phase != 0) begin
        m_ovr = 1;
        if (m_cnt < 255) m_cnt++;
      end
      if (lrs) begin
        m_phase = 1; m_pend = {en2, en1, en0}; m_idx = line_idx;
      end else if (m_phase == 1) begin
        if (m_pend == 0) begin m_phase = 0; m_done = 1; m_bank = ~m_bank; end
        else m_phase = 2;
      end else if (m_phase == 2) begin
        m_pend = m_pend & ~rnd_done;
        if (m_pend == 0) begin m_phase = 0; m_done = 1; m_bank = ~m_bank; end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [2:0] eg;
    int ei;
    logic [AW-1:0] ea;
    if (armed) begin
      eg = pick(m_elig(), m_ptr);
      ei = gidx(eg);
      ea = (ei >= 0) ? rnd_vram_addr[ei*AW +: AW] : '0;
      chk("m_start", rnd_start, (m_phase == 1) ? m_pend : 3'b000);
      chk("m_idx", rnd_line_idx, m_idx);
      chk("m_gnt", rnd_vram_gnt, eg);
      chk("m_rden", vram_rd_en, |eg);
      chk("m_addr", vram_addr, ea);
      chk("m_rdv", rnd_vram_rdvalid, m_rdv);
      chk("m_bank", lb_render_bank, m_bank);
      chk("m_ldone", line_done, m_done);
      chk("m_ovr", overrun, m_ovr);
      chk("m_cnt", overrun_count, m_cnt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  logic [2:0] arb_seq [3];
  int b;

  initial begin
`ifdef LRS_SPRITE_PRIORITY_EN
    arb_seq[0] = 3'b100; arb_seq[1] = 3'b100; arb_seq[2] = 3'b100;
`else
    arb_seq[0] = 3'b001; arb_seq[1] = 3'b010; arb_seq[2] = 3'b100;
`endif
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #3;
    chk("rst_bank", lb_render_bank, 0);
    chk("rst_cnt", overrun_count, 0);
    chk("rst_start", rnd_start, 0);
    chk("rst_ldone", line_done, 0);

    // all enabled, line 37, staggered dones
    tick(); lrs = 1; line_idx = 9'd37; {en2, en1, en0} = 3'b111; b = cyc;
    tick(); lrs = 0;
    #3;
    chk("t1_start", rnd_start, 3'b111);
    chk("t1_idx", rnd_line_idx, 37);
    wait_to(b + 5); rnd_done = 3'b001; tick(); rnd_done = 0;
    wait_to(b + 9); rnd_done = 3'b010; tick(); rnd_done = 0;
    #3 chk("t1_early", line_done, 0);
    wait_to(b + 12); rnd_done = 3'b100; tick(); rnd_done = 0;
    #3;
    chk("t1_ldone", line_done, 1);
    chk("t1_bank", lb_render_bank, 1);
    tick();
    #3 chk("t1_once", line_done, 0);

    // only layer1; layer0 done is ignored
    tick(); lrs = 1; line_idx = 9'd5; {en2, en1, en0} = 3'b010; b = cyc;
    tick(); lrs = 0;
    #3 chk("t2_start", rnd_start, 3'b010);
    wait_to(b + 3); rnd_done = 3'b001; tick(); rnd_done = 0;
    #3 chk("t2_ign", line_done, 0);
    wait_to(b + 6); rnd_done = 3'b010; tick(); rnd_done = 0;
    #3;
    chk("t2_ldone", line_done, 1);
    chk("t2_bank", lb_render_bank, 0);

    // nothing enabled
    tick(); lrs = 1; line_idx = 9'd6; {en2, en1, en0} = 3'b000;
    tick(); lrs = 0;
    #3 chk("t3_start", rnd_start, 0);
    tick();
    #3;
    chk("t3_ldone", line_done, 1);
    chk("t3_bank", lb_render_bank, 1);

    // arbitration with all three requesting
    tick(); lrs = 1; line_idx = 9'd100; {en2, en1, en0} = 3'b111;
    tick(); lrs = 0; rnd_vram_req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      tick();
      #3 chk("t4_gnt", rnd_vram_gnt, arb_seq[k % 3]);
      if (k == 0) chk("t4_addr", vram_addr, arb_seq[0][2] ? 17'h1_3333 : 17'h0_0111);
    end
    tick(); rnd_vram_req = 3'b001; rnd_done = 3'b111;
    tick(); rnd_vram_req = 0; rnd_done = 0;
    #3;
    chk("t4_rdv_done", rnd_vram_rdvalid, 3'b001);
    chk("t4_ldone", line_done, 1);
    chk("t4_bank", lb_render_bank, 0);

    // overrun while sprites pending
    tick(); lrs = 1; line_idx = 9'd10; {en2, en1, en0} = 3'b111; b = cyc;
    tick(); lrs = 0;
    wait_to(b + 3); rnd_done = 3'b001; tick(); rnd_done = 3'b010; tick(); rnd_done = 0;
    wait_to(b + 7); lrs = 1; line_idx = 9'd11;
    tick(); lrs = 0;
    #3;
    chk("t5_ovr", overrun, 1);
    chk("t5_cnt", overrun_count, 1);
    chk("t5_restart", rnd_start, 3'b111);
    chk("t5_idx", rnd_line_idx, 11);
    chk("t5_bank", lb_render_bank, 0);
    chk("t5_ldone", line_done, 0);
    overrun_clr = 1;
    tick(); overrun_clr = 0;
    #3;
    chk("t5_clr_ovr", overrun, 0);
    chk("t5_clr_cnt", overrun_count, 0);
    lrs = 1; line_idx = 9'd12;
    repeat (256) tick();
    lrs = 0;
    #3;
    chk("t5_sat", overrun_count, 255);
    chk("t5_sat_ovr", overrun, 1);
    overrun_clr = 1;
    tick(); overrun_clr = 0;
    #3;
    chk("t5_clr2", overrun_count, 0);
    rnd_done = 3'b111;
    tick(); rnd_done = 0;
    #3;
    chk("t5_ldone2", line_done, 1);
    chk("t5_bank2", lb_render_bank, 1);

    // reset mid-render with a grant active
    tick(); lrs = 1; line_idx = 9'd200; {en2, en1, en0} = 3'b111;
    tick(); lrs = 0;
    tick(); rnd_vram_req = 3'b001;
    #3 chk("t6_gnt", rnd_vram_gnt, 3'b001);
    rst = 1;
    tick(); rst = 0;
    #3;
    chk("t6_rdv", rnd_vram_rdvalid, 0);
    chk("t6_gnt0", rnd_vram_gnt, 0);
    chk("t6_rden", vram_rd_en, 0);
    chk("t6_bank", lb_render_bank, 0);
    chk("t6_idx", rnd_line_idx, 0);
    rnd_vram_req = 0;
    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
